mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, memory word width (byte mode requires 16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word address width.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_byte  in  1  byte store select; honoured only with MEM_BYTE_WRITE_EN.
REQ-009 SHALL have port req_hi  in  1  byte lane select: 1 = bits [15:8], 0 = bits [7:0].
REQ-010 SHALL have port req_addr  in  ADDR_WIDTH  word address.
REQ-011 SHALL have port req_wdata  in  DATA_WIDTH  store data; the byte store uses [7:0].
REQ-012 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata  out  DATA_WIDTH  load data or merged store word.
REQ-014 SHALL have port mem_addr  out  ADDR_WIDTH  to the RAM address input.
REQ-015 SHALL have port mem_data  out  DATA_WIDTH  to the RAM write-data input.
REQ-016 SHALL have port mem_we  out  1  to the RAM write enable.
REQ-017 SHALL have port mem_q  in  DATA_WIDTH  from the RAM; valid one cycle after mem_addr is sampled.

Function
REQ-018 SHALL use states IDLE, ISSUE, CAPTURE, WRITE, RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE; no request is accepted in any other state.
REQ-020 SHALL latch req_addr, req_wdata, req_we, req_byte and req_hi into registers on acceptance.
REQ-021 SHALL drive mem_addr and mem_data from the latched registers in all non-IDLE states.
REQ-022 SHALL follow the load path IDLE->ISSUE->CAPTURE->RESP, capturing mem_q into rsp_rdata at the end of CAPTURE.
REQ-023 SHALL follow the word-store path IDLE->WRITE->RESP.
REQ-024 SHALL assert mem_we only in WRITE, gated by !rst, so no write commits in a reset cycle.
REQ-025 SHALL pulse rsp_valid for exactly one cycle in RESP with no backpressure, then return to IDLE.
REQ-026 SHALL give a load accepted in cycle A rsp_valid in cycle A+3, and a word store rsp_valid in cycle A+2.
REQ-027 SHALL set rsp_rdata on a word store to the stored word.
REQ-028 SHALL hold rsp_rdata stable outside RESP until the next capture.
REQ-029 SHALL accept the next request no earlier than the cycle after RESP.
REQ-030 SHALL treat all 2**ADDR_WIDTH addresses as valid, with no wrap or alias logic.

Reset
REQ-031 SHALL, when rst is sampled high, force the next state to IDLE and zero every output and latched register.
REQ-032 SHALL drive req_ready=0 in the reset cycle and 1 in the first cycle after rst falls.
REQ-033 SHALL, on reset mid-operation, abandon the operation with no rsp_valid and no mem_we pulse.

Configuration
REQ-034 SHALL implement byte stores under macro MEM_BYTE_WRITE_EN.
REQ-035 SHALL, with MEM_BYTE_WRITE_EN defined, run a store with req_byte=1 as IDLE->ISSUE->CAPTURE->WRITE->RESP.
REQ-036 SHALL, in that byte store path, write mem_q with the selected lane replaced by req_wdata[7:0], and return the merged word on rsp_rdata in cycle A+4.
REQ-037 SHALL, without MEM_BYTE_WRITE_EN, ignore req_byte and req_hi; every store is a word store.

Structure
REQ-038 SHALL place the state enum typedef and default width constants in package mem_access_pkg.
REQ-039 SHALL place the lane merge in sub-module mem_byte_merge, a combinational merge of word, byte and lane, instantiated only with MEM_BYTE_WRITE_EN.

Verification
REQ-040 SHALL cover: store 0xBEEF to 0x005, then load 0x005 -> rsp_rdata=0xBEEF at acceptance+3, and mem_we high for exactly 1 cycle.
REQ-041 SHALL cover: req_valid held high with two loads queued -> second accepted exactly 4 cycles after the first, and req_ready low in between.
REQ-042 SHALL cover: with the macro, word 0xBEEF at 0x010 and a byte store 0x12 with req_hi=1 -> memory and rsp_rdata = 0x12EF; with req_hi=0 -> 0xBE12.
REQ-043 SHALL cover: rst asserted during the WRITE of a store 0x1234 to 0x020 -> mem_we stays 0, no rsp_valid, memory unchanged, req_ready=1 the cycle after rst falls.
REQ-044 SHALL cover: store then load 0xA5A5 at 0x3FF and 0x000 -> both read back with no aliasing.
REQ-045 SHALL cover: without the macro, req_byte=1 with store 0x00FF -> full word 0x00FF written, and rsp_valid at acceptance+2.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared state encoding and default widths for the memory access controller.
package mem_access_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefAddrWidth = 10;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StCapture,
        StWrite,
        StResp
    } state_e;

endpackage

// File: rtl/mem_byte_merge.sv
// Combinational lane merge: replaces one byte lane of a 16-bit word with a new byte.
module mem_byte_merge
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [7:0]            byte_i,
    input  logic                  hi_i,
    output logic [DATA_WIDTH-1:0] merged_o
);

    always_comb begin
        merged_o = word_i;
        if (hi_i) begin
            merged_o[15:8] = byte_i;
        end else begin
            merged_o[7:0] = byte_i;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-port RAM access sequencer for loads and word stores; defining MEM_BYTE_WRITE_EN
// adds read-modify-write byte stores through mem_byte_merge.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_byte,
    input  logic                  req_hi,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  we_q;
    logic                  rsp_valid_q;
    logic                  byte_sel;
    logic                  byte_store;

`ifdef MEM_BYTE_WRITE_EN
    logic byte_q;
    logic hi_q;

    assign byte_sel   = req_byte;
    assign byte_store = we_q & byte_q;

    mem_byte_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_byte_merge (
        .word_i  (mem_q),
        .byte_i  (wdata_q[7:0]),
        .hi_i    (hi_q),
        .merged_o(merged_word)
    );
`else
    logic unused_lane_sel;

    assign unused_lane_sel = req_byte ^ req_hi;
    assign byte_sel        = 1'b0;
    assign byte_store      = 1'b0;
    assign merged_word     = mem_q;
`endif

    // Gated by rst so a reset cycle neither accepts a request nor commits a write.
    assign req_ready = (state_q == StIdle) && !rst;
    assign mem_we    = (state_q == StWrite) && !rst;
    assign mem_addr  = addr_q;
    assign mem_data  = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef MEM_BYTE_WRITE_EN
            byte_q      <= 1'b0;
            hi_q        <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        we_q    <= req_we;
`ifdef MEM_BYTE_WRITE_EN
                        byte_q  <= req_byte;
                        hi_q    <= req_hi;
`endif
                        state_q <= (req_we && !byte_sel) ? StWrite : StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StCapture;
                end
                StCapture: begin
                    // Byte stores fold the read word into the write data before WRITE.
                    if (byte_store) begin
                        wdata_q <= merged_word;
                        state_q <= StWrite;
                    end else begin
                        rsp_rdata_q <= mem_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StWrite: begin
                    rsp_rdata_q <= wdata_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a synchronous RAM model; byte-store scenarios
// run when MEM_BYTE_WRITE_EN is defined, the word-only scenario otherwise.
module tb_mem_access_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic          req_byte;
    logic          req_hi;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    logic [DW-1:0] ram [0:1023];
    int unsigned   we_total = 0;
    int            checks   = 0;
    int            passes   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we === 1'b1) we_total <= we_total + 1;
    end

    mem_access_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_byte (req_byte),
        .req_hi   (req_hi),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_q    (mem_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in an IDLE cycle; returns in the cycle after acceptance.
    task automatic issue(input logic we, input logic bsel, input logic hi,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = bsel;
        req_hi    = hi;
        req_addr  = addr;
        req_wdata = data;
        tick();
        req_valid = 1'b0;
        req_byte  = 1'b0;
        req_hi    = 1'b0;
    endtask

    task automatic store_word(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        issue(1'b1, 1'b0, 1'b0, addr, data);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", req_ready);
        else passes++;
        checks++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        else passes++;
        checks++;
        if (rsp_rdata !== 16'h0000) $display("FAIL reset_rsp_rdata: got %h want 0000", rsp_rdata);
        else passes++;
        checks++;
        if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we);
        else passes++;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", req_ready);
        else passes++;
        checks++;
        if (mem_addr !== 10'h000) $display("FAIL reset_mem_addr: got %h want 000", mem_addr);
        else passes++;
        tick();
    endtask

    task automatic test_store_load();
        int unsigned w0;
        w0 = we_total;
        issue(1'b1, 1'b0, 1'b0, 10'h005, 16'hBEEF);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 10'h005 || mem_data !== 16'hBEEF)
            $display("FAIL store_write_cycle: got we=%b addr=%h data=%h want 1/005/beef",
                     mem_we, mem_addr, mem_data);
        else passes++;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL store_ready_busy: got %b want 0", req_ready);
        else passes++;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF)
            $display("FAIL store_rsp: got v=%b d=%h want 1/beef", rsp_valid, rsp_rdata);
        else passes++;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL store_rsp_one_cycle: got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
        else passes++;
        checks++;
        if (we_total - w0 !== 1)
            $display("FAIL store_we_pulses: got %0d want 1", we_total - w0);
        else passes++;
        issue(1'b0, 1'b0, 1'b0, 10'h005, 16'h0000);
        checks++;
        if (mem_we !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL load_issue: got we=%b v=%b want 0/0", mem_we, rsp_valid);
        else passes++;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) $display("FAIL load_early_rsp: got %b want 0", rsp_valid);
        else passes++;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF)
            $display("FAIL load_rsp: got v=%b d=%h want 1/beef", rsp_valid, rsp_rdata);
        else passes++;
        tick();
        checks++;
        if (rsp_rdata !== 16'hBEEF || rsp_valid !== 1'b0)
            $display("FAIL load_hold: got v=%b d=%h want 0/beef", rsp_valid, rsp_rdata);
        else passes++;
        store_word(10'h006, 16'h5A5A);
    endtask

    task automatic test_back_to_back();
        int   gap;
        int   low;
        logic rv;
        logic [DW-1:0] rd;
        gap = 0;
        low = 0;
        rv  = 1'b0;
        rd  = '0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'h005;
        #1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL b2b_first_ready: got %b want 1", req_ready);
        else passes++;
        do begin
            tick();
            req_addr = 10'h006;
            gap++;
            if (req_ready === 1'b0) low++;
            if (gap == 3) begin
                rv = rsp_valid;
                rd = rsp_rdata;
            end
        end while (req_ready !== 1'b1 && gap < 10);
        checks++;
        if (gap != 4) $display("FAIL b2b_gap: got %0d want 4", gap);
        else passes++;
        checks++;
        if (low != 3) $display("FAIL b2b_ready_low: got %0d want 3", low);
        else passes++;
        checks++;
        if (rv !== 1'b1 || rd !== 16'hBEEF)
            $display("FAIL b2b_first_rsp: got v=%b d=%h want 1/beef", rv, rd);
        else passes++;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h5A5A)
            $display("FAIL b2b_second_rsp: got v=%b d=%h want 1/5a5a", rsp_valid, rsp_rdata);
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid_write();
        int unsigned w0;
        store_word(10'h020, 16'h7777);
        w0 = we_total;
        issue(1'b1, 1'b0, 1'b0, 10'h020, 16'h1234);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) $display("FAIL rstw_mem_we: got %b want 0", mem_we);
        else passes++;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL rstw_ready_after: got %b want 1", req_ready);
        else passes++;
        checks++;
        if (rsp_valid !== 1'b0) $display("FAIL rstw_rsp_valid: got %b want 0", rsp_valid);
        else passes++;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || we_total != w0)
            $display("FAIL rstw_no_completion: got v=%b we_pulses=%0d want 0/0",
                     rsp_valid, we_total - w0);
        else passes++;
        checks++;
        if (ram[10'h020] !== 16'h7777)
            $display("FAIL rstw_mem_unchanged: got %h want 7777", ram[10'h020]);
        else passes++;
    endtask

    task automatic test_boundary();
        issue(1'b1, 1'b0, 1'b0, 10'h3FF, 16'hA5A5);
        checks++;
        if (mem_addr !== 10'h3FF) $display("FAIL bnd_top_addr: got %h want 3ff", mem_addr);
        else passes++;
        tick();
        tick();
        store_word(10'h000, 16'h5AA5);
        issue(1'b0, 1'b0, 1'b0, 10'h3FF, 16'h0000);
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5A5)
            $display("FAIL bnd_load_top: got v=%b d=%h want 1/a5a5", rsp_valid, rsp_rdata);
        else passes++;
        tick();
        issue(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h5AA5)
            $display("FAIL bnd_load_zero: got v=%b d=%h want 1/5aa5", rsp_valid, rsp_rdata);
        else passes++;
        tick();
    endtask

`ifdef MEM_BYTE_WRITE_EN
    task automatic test_byte_store();
        store_word(10'h010, 16'hBEEF);
        issue(1'b1, 1'b1, 1'b1, 10'h010, 16'h0012);
        checks++;
        if (mem_we !== 1'b0) $display("FAIL byte_issue_we: got %b want 0", mem_we);
        else passes++;
        tick();
        checks++;
        if (mem_we !== 1'b0) $display("FAIL byte_capture_we: got %b want 0", mem_we);
        else passes++;
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_data !== 16'h12EF)
            $display("FAIL byte_hi_write: got we=%b d=%h want 1/12ef", mem_we, mem_data);
        else passes++;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h12EF || ram[10'h010] !== 16'h12EF)
            $display("FAIL byte_hi_rsp: got v=%b d=%h mem=%h want 1/12ef/12ef",
                     rsp_valid, rsp_rdata, ram[10'h010]);
        else passes++;
        tick();
        store_word(10'h010, 16'hBEEF);
        issue(1'b1, 1'b1, 1'b0, 10'h010, 16'h0012);
        tick();
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBE12 || ram[10'h010] !== 16'hBE12)
            $display("FAIL byte_lo_rsp: got v=%b d=%h mem=%h want 1/be12/be12",
                     rsp_valid, rsp_rdata, ram[10'h010]);
        else passes++;
        tick();
    endtask
`else
    task automatic test_byte_ignored();
        store_word(10'h030, 16'hFFFF);
        issue(1'b1, 1'b1, 1'b1, 10'h030, 16'h00FF);
        checks++;
        if (mem_we !== 1'b1 || mem_data !== 16'h00FF)
            $display("FAIL word_only_write: got we=%b d=%h want 1/00ff", mem_we, mem_data);
        else passes++;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h00FF)
            $display("FAIL word_only_rsp: got v=%b d=%h want 1/00ff", rsp_valid, rsp_rdata);
        else passes++;
        tick();
        checks++;
        if (ram[10'h030] !== 16'h00FF)
            $display("FAIL word_only_mem: got %h want 00ff", ram[10'h030]);
        else passes++;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_hi    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_reset_mid_write();
        test_boundary();
`ifdef MEM_BYTE_WRITE_EN
        test_byte_store();
`else
        test_byte_ignored();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
